// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: N-to-1 valid/ready stream mux with fixed or round-robin selection and a registered output
module mux_nto1_stream #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int S = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           mode_in,
    input  logic [S-1:0]   sel_in,
    input  logic [N*W-1:0] d_in,
    input  logic [N-1:0]   valid_in,
    output logic [N-1:0]   ready_out,
    output logic [W-1:0]   y_out,
    output logic           y_valid_out,
    input  logic           y_ready_in,
    output logic [S-1:0]   ch_out,
    output logic           sel_err_out
);
    localparam logic [2**S-1:0] SEL_MASK = {(2**S){1'b1}} >> (2**S - N);
    logic [S-1:0] ptr, k, idx;
    logic gnt, accept, xfer, sel_ok;
    assign accept = !y_valid_out || y_ready_in;
    assign sel_ok = SEL_MASK[sel_in];
    always_comb begin
        k = sel_ok ? sel_in : '0;
        gnt = sel_ok;
        idx = '0;
        if (mode_in) begin
            k = '0;
            gnt = 1'b0;
            for (int j = N - 1; j >= 0; j--) begin
                idx = S'((int'(ptr) + j) % N);
                if (valid_in[idx]) begin
                    k = idx;
                    gnt = 1'b1;
                end
            end
        end
    end
    assign xfer = accept && gnt && valid_in[k];
    assign ready_out = (accept && gnt && !rst_in) ? N'(1) << k : '0;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr <= '0;
            y_out <= '0;
            ch_out <= '0;
            y_valid_out <= 1'b0;
            sel_err_out <= 1'b0;
        end else begin
            if (!mode_in && !sel_ok) sel_err_out <= 1'b1;
            if (xfer && mode_in) ptr <= (int'(k) == N - 1) ? '0 : k + 1'b1;
            if (accept) begin
                y_valid_out <= xfer;
                if (xfer) begin
                    y_out <= d_in[int'(k)*W +: W];
                    ch_out <= k;
                end
            end
        end
    end
endmodule
